// File: rtl/inst_axi_pkg.sv
// Shared definitions for the instruction-side SRAM-like to AXI read path.
// Holds the bus widths, the constant AR burst encodings and the AR FSM state type.
package inst_axi_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FETCH_W = 64;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  // Wide enough for an outstanding limit of up to 4.
  localparam int unsigned CNT_W   = 3;

  localparam logic [LEN_W-1:0]   AXI_LEN_2BEAT  = LEN_W'(1);
  localparam logic [SIZE_W-1:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

endpackage

// File: rtl/ostd_tracker.sv
// Outstanding-fetch and cancelled-fetch counters.
// Ports: inc_i (fetch accepted), dec_i (last R beat handshaken), flush_i,
//        ostd_cnt_o (fetches in flight, cancelled ones included),
//        cancel_cnt_o (responses still to be dropped).
module ostd_tracker
  import inst_axi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] ostd_cnt_o,
  output logic [CNT_W-1:0] cancel_cnt_o
);

  logic [CNT_W-1:0] ostd_q, ostd_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic             dec_c;

  // A stray rlast with nothing in flight must not wrap the counter.
  assign dec_c = dec_i & (ostd_q != '0);

  // Next-state rules for both counters.
  always_comb begin
    ostd_d   = ostd_q;
    cancel_d = cancel_q;
    if (inc_i && !dec_c) begin
      ostd_d = ostd_q + CNT_W'(1);
    end else if (dec_c && !inc_i) begin
      ostd_d = ostd_q - CNT_W'(1);
    end
    // A response finishing in the flush cycle is dropped by the flush itself,
    // so only the fetches still in flight afterwards need cancelling.
    if (flush_i) begin
      cancel_d = ostd_q - CNT_W'(dec_c) + CNT_W'(inc_i);
    end else if (dec_c && (cancel_q != '0)) begin
      cancel_d = cancel_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ostd_q   <= '0;
      cancel_q <= '0;
    end else begin
      ostd_q   <= ostd_d;
      cancel_q <= cancel_d;
    end
  end

  assign ostd_cnt_o   = ostd_q;
  assign cancel_cnt_o = cancel_q;

endmodule

// File: rtl/inst_sram_axi_rd.sv
// Instruction fetch responder: accepts SRAM-like fetch requests and turns each
// into a 2-beat AXI4 INCR read returning {inst@pc+4, inst@pc}.
// Ports: inst_sram_* fetch handshake (addr_ok combinational, data_ok one-cycle
//        pulse with registered rdata), flush_i cancels in-flight fetches,
//        ar*/r* AXI4 read address and read data channels.
module inst_sram_axi_rd
  import inst_axi_pkg::*;
#(
  parameter int unsigned     OSTD_MAX = 2,
  parameter logic [ID_W-1:0] AXI_ID   = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_sram_req_i,
  input  logic [ADDR_W-1:0]  inst_sram_raddr_i,
  output logic               inst_sram_addr_ok_o,
  output logic               inst_sram_data_ok_o,
  output logic [FETCH_W-1:0] inst_sram_rdata_o,
  input  logic               flush_i,
  output logic [ID_W-1:0]    arid_o,
  output logic [ADDR_W-1:0]  araddr_o,
  output logic [LEN_W-1:0]   arlen_o,
  output logic [SIZE_W-1:0]  arsize_o,
  output logic [BURST_W-1:0] arburst_o,
  output logic               arvalid_o,
  input  logic               arready_i,
  input  logic [ID_W-1:0]    rid_i,
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [RESP_W-1:0]  rresp_i,
  input  logic               rlast_i,
  input  logic               rvalid_i,
  output logic               rready_o
);

  ar_state_e          ar_state_q;
  logic [ADDR_W-1:0]  araddr_q;
  logic               arvalid_q;
  logic               rready_q;
  logic               beat_sel_q;
  logic               data_ok_q;
  logic [DATA_W-1:0]  beat0_q;
  logic [FETCH_W-1:0] rdata_q;

  logic               addr_ok_c;
  logic               r_hs_c;
  logic               r_last_hs_c;
  logic               suppress_c;
  logic [CNT_W-1:0]   ostd_cnt;
  logic [CNT_W-1:0]   cancel_cnt;
  logic               unused_c;

  // Single ID with in-order responses, and error responses are forwarded as data.
  assign unused_c = ^{rid_i, rresp_i};

  // rready_q doubles as the out-of-reset flag so addr_ok is low during reset.
  assign addr_ok_c   = inst_sram_req_i & ~flush_i & rready_q &
                       (ar_state_q == AR_IDLE) & (ostd_cnt < CNT_W'(OSTD_MAX));
  assign r_hs_c      = rvalid_i & rready_q;
  assign r_last_hs_c = r_hs_c & rlast_i;
  // A flush in the same cycle as rlast also drops that response.
  assign suppress_c  = flush_i | (cancel_cnt != '0);

  ostd_tracker u_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_i        (addr_ok_c),
    .dec_i        (r_last_hs_c),
    .flush_i      (flush_i),
    .ostd_cnt_o   (ostd_cnt),
    .cancel_cnt_o (cancel_cnt)
  );

  // AR channel FSM; an issued AR is held until accepted even across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (addr_ok_c) begin
            araddr_q   <= inst_sram_raddr_i;
            arvalid_q  <= 1'b1;
            ar_state_q <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (arready_i) begin
            arvalid_q  <= 1'b0;
            ar_state_q <= AR_IDLE;
          end
        end
        default: begin
          arvalid_q  <= 1'b0;
          ar_state_q <= AR_IDLE;
        end
      endcase
    end
  end

  // R channel: stage beat 0, publish both words on the last beat so rdata
  // only changes together with data_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rready_q   <= 1'b0;
      beat_sel_q <= 1'b0;
      data_ok_q  <= 1'b0;
      beat0_q    <= '0;
      rdata_q    <= '0;
    end else begin
      rready_q  <= 1'b1;
      data_ok_q <= r_last_hs_c & ~suppress_c;
      if (r_hs_c) begin
        beat_sel_q <= rlast_i ? 1'b0 : ~beat_sel_q;
        if (!beat_sel_q && !rlast_i) begin
          beat0_q <= rdata_i;
        end
        if (rlast_i && !suppress_c) begin
          rdata_q <= {rdata_i, beat0_q};
        end
      end
    end
  end

  assign inst_sram_addr_ok_o = addr_ok_c;
  assign inst_sram_data_ok_o = data_ok_q;
  assign inst_sram_rdata_o   = rdata_q;
  assign arid_o              = AXI_ID;
  assign araddr_o            = araddr_q;
  assign arlen_o             = AXI_LEN_2BEAT;
  assign arsize_o            = AXI_SIZE_4B;
  assign arburst_o           = AXI_BURST_INCR;
  assign arvalid_o           = arvalid_q;
  assign rready_o            = rready_q;

endmodule

// File: tb/tb_inst_sram_axi_rd.sv
// Bench for inst_sram_axi_rd: a randomising AXI slave, a transaction-level
// reference of accepted/cancelled fetches, and one task per scenario.
module tb_inst_sram_axi_rd;

  localparam int unsigned OSTD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] raddr;
  logic        flush;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;

  logic        addr_ok_o, data_ok_o, arvalid_o, rready_o;
  logic [63:0] rdata_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [31:0] addr; logic cancelled; } fetch_t;
  fetch_t      fq[$];
  bit          ar_pending = 0;
  logic [31:0] ar_addr = '0;
  bit          exp_dok = 0;
  logic [63:0] exp_rdata = '0;
  bit          up = 0;
  int          dok_cnt = 0, exp_dok_total = 0, rlast_cnt = 0, ar_cnt = 0;

  int          ar_mode = 0;   // 0 always ready, 1 never ready, 2 random
  int          r_gap_pct = 0;
  bit          r_hold = 0;
  logic [31:0] sl_q[$];
  bit          sl_beat = 0;

  inst_sram_axi_rd #(.OSTD_MAX(OSTD), .AXI_ID(4'd0)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .inst_sram_req_i (req), .inst_sram_raddr_i (raddr),
    .inst_sram_addr_ok_o (addr_ok_o), .inst_sram_data_ok_o (data_ok_o),
    .inst_sram_rdata_o (rdata_o), .flush_i (flush),
    .arid_o (arid_o), .araddr_o (araddr_o), .arlen_o (arlen_o), .arsize_o (arsize_o),
    .arburst_o (arburst_o), .arvalid_o (arvalid_o), .arready_i (arready_i),
    .rid_i (rid_i), .rdata_i (rdata_i), .rresp_i (rresp_i), .rlast_i (rlast_i),
    .rvalid_i (rvalid_i), .rready_o (rready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h1111_1111;
    if (a == 32'h1C00_0004) return 32'h2222_2222;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AXI slave: memory behind the read channel with configurable back-pressure.
  initial begin
    bit          ar_hs, r_hs;
    logic [31:0] ar_a;
    forever begin
      @(negedge clk);
      ar_hs = arvalid_o & arready_i;
      r_hs  = rvalid_i & rready_o;
      ar_a  = araddr_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sl_q.delete();
        rvalid_i = 0; rlast_i = 0; sl_beat = 0; arready_i = 0;
        continue;
      end
      if (ar_hs) sl_q.push_back(ar_a);
      if (r_hs) begin
        if (rlast_i) begin
          void'(sl_q.pop_front());
          sl_beat = 0;
        end else begin
          sl_beat = 1;
        end
        rvalid_i = 0;
        rlast_i  = 0;
      end
      arready_i = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!rvalid_i && sl_q.size() != 0 && !r_hold && ($urandom_range(0, 99) >= r_gap_pct)) begin
        rvalid_i = 1;
        rlast_i  = sl_beat;
        rdata_i  = mem(sl_q[0] + (sl_beat ? 32'd4 : 32'd0));
        rid_i    = 4'($urandom_range(0, 15));
        rresp_i  = 2'($urandom_range(0, 3));
      end
    end
  end

  // Reference: ordered list of accepted fetches, each marked cancelled by a flush.
  always @(negedge clk) begin
    bit exp_aok;
    fetch_t f;
    if (!rst_n) begin
      fq.delete();
      ar_pending = 0; exp_dok = 0; exp_rdata = '0; up = 0;
    end else begin
      vectors++;
      if (data_ok_o !== exp_dok) begin
        $display("FAIL data_ok: got %b want %b at %0t", data_ok_o, exp_dok, $time); miscompares++;
      end
      if (rdata_o !== exp_rdata) begin
        $display("FAIL rdata: got %h want %h at %0t", rdata_o, exp_rdata, $time); miscompares++;
      end
      if (arvalid_o !== ar_pending || (ar_pending && araddr_o !== ar_addr)) begin
        $display("FAIL ar_chan: got arvalid %b araddr %h want %b %h at %0t",
                 arvalid_o, araddr_o, ar_pending, ar_addr, $time); miscompares++;
      end
      exp_aok = up && req && !flush && !ar_pending && (fq.size() < OSTD);
      if (addr_ok_o !== exp_aok) begin
        $display("FAIL addr_ok: got %b want %b at %0t", addr_ok_o, exp_aok, $time); miscompares++;
      end
      if (rready_o !== up) begin
        $display("FAIL rready: got %b want %b at %0t", rready_o, up, $time); miscompares++;
      end
      if (data_ok_o === 1'b1) dok_cnt++;
      if (arvalid_o && arready_i) ar_cnt++;
      exp_dok = 0;
      if (ar_pending && arready_i) ar_pending = 0;
      if (flush) foreach (fq[i]) fq[i].cancelled = 1'b1;
      if (up && rvalid_i && rlast_i) begin
        rlast_cnt++;
        if (fq.size() == 0) begin
          $display("FAIL r_order: got rlast with no fetch want none at %0t", $time); miscompares++;
        end else begin
          f = fq.pop_front();
          if (!f.cancelled) begin
            exp_dok = 1;
            exp_rdata = {mem(f.addr + 32'd4), mem(f.addr)};
            exp_dok_total++;
          end
        end
      end
      if (exp_aok) begin
        fq.push_back('{addr: raddr, cancelled: 1'b0});
        ar_pending = 1;
        ar_addr = raddr;
      end
      up = 1;
    end
  end

  task automatic issue(input logic [31:0] a);
    bit got = 0;
    req = 1; raddr = a;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (addr_ok_o === 1'b1) got = 1;
      tick();
    end
    req = 0;
    vectors++;
    if (!got) begin
      $display("FAIL issue_timeout: addr %h got no addr_ok want addr_ok", a); miscompares++;
    end
  endtask

  task automatic drain();
    bit done = 0;
    req = 0; flush = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (fq.size() == 0 && !ar_pending && !rvalid_i) done = 1;
      tick();
    end
    repeat (3) tick();
    vectors++;
    if (!done) begin
      $display("FAIL drain_timeout: got %0d fetches pending want 0", fq.size()); miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req = 1; raddr = 32'h1C00_0000;
    tick(); tick();
    @(negedge clk);
    vectors += 6;
    if (addr_ok_o !== 1'b0) begin $display("FAIL rst_addr_ok: got %b want 0", addr_ok_o); miscompares++; end
    if (data_ok_o !== 1'b0) begin $display("FAIL rst_data_ok: got %b want 0", data_ok_o); miscompares++; end
    if (rdata_o !== 64'd0) begin $display("FAIL rst_rdata: got %h want 0", rdata_o); miscompares++; end
    if (arvalid_o !== 1'b0) begin $display("FAIL rst_arvalid: got %b want 0", arvalid_o); miscompares++; end
    if (araddr_o !== 32'd0) begin $display("FAIL rst_araddr: got %h want 0", araddr_o); miscompares++; end
    if (rready_o !== 1'b0) begin $display("FAIL rst_rready: got %b want 0", rready_o); miscompares++; end
    tick(); req = 0;
    tick(); rst_n = 1;
    tick(); tick();
  endtask

  task automatic test_single();
    ar_mode = 0; r_gap_pct = 0; r_hold = 0;
    tick();
    req = 1; raddr = 32'h1C00_0000;
    @(negedge clk);
    vectors++;
    if (addr_ok_o !== 1'b1) begin $display("FAIL single_aok: got %b want 1", addr_ok_o); miscompares++; end
    tick(); req = 0;
    @(negedge clk);
    vectors += 3;
    if (arvalid_o !== 1'b1 || araddr_o !== 32'h1C00_0000) begin
      $display("FAIL single_ar: got %b %h want 1 1c000000", arvalid_o, araddr_o); miscompares++;
    end
    if (arlen_o !== 8'd1 || arsize_o !== 3'b010) begin
      $display("FAIL single_len_size: got %h %b want 01 010", arlen_o, arsize_o); miscompares++;
    end
    if (arburst_o !== 2'b01 || arid_o !== 4'd0) begin
      $display("FAIL single_burst_id: got %b %h want 01 0", arburst_o, arid_o); miscompares++;
    end
    tick(); tick();
    @(negedge clk);
    vectors++;
    if (data_ok_o !== 1'b0) begin $display("FAIL single_early_dok: got %b want 0", data_ok_o); miscompares++; end
    tick();
    @(negedge clk);
    vectors++;
    if (data_ok_o !== 1'b1 || rdata_o !== 64'h2222_2222_1111_1111) begin
      $display("FAIL single_dok: got %b %h want 1 2222222211111111", data_ok_o, rdata_o); miscompares++;
    end
    drain();
  endtask

  task automatic test_ar_stall();
    bit got = 0;
    ar_mode = 1;
    tick(); tick();
    req = 1; raddr = 32'h1C00_0040;
    @(negedge clk);
    vectors++;
    if (addr_ok_o !== 1'b1) begin $display("FAIL stall_aok0: got %b want 1", addr_ok_o); miscompares++; end
    tick(); raddr = 32'h1C00_0080;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (arvalid_o !== 1'b1 || araddr_o !== 32'h1C00_0040 || addr_ok_o !== 1'b0) begin
        $display("FAIL stall_hold: got arvalid %b araddr %h aok %b want 1 1c000040 0",
                 arvalid_o, araddr_o, addr_ok_o); miscompares++;
      end
      tick();
    end
    ar_mode = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (addr_ok_o === 1'b1) got = 1;
      tick();
    end
    req = 0;
    vectors++;
    if (!got) begin $display("FAIL stall_second: got no addr_ok want addr_ok"); miscompares++; end
    drain();
  endtask

  task automatic test_ostd_limit();
    int accepts = 0;
    int rl0;
    bit got = 0;
    bit aok;
    r_hold = 1; ar_mode = 0;
    req = 1; raddr = 32'h1C00_1000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      aok = addr_ok_o;
      if (aok) accepts++;
      tick();
      if (aok) raddr = raddr + 32'h40;
    end
    vectors++;
    if (accepts != OSTD) begin $display("FAIL ostd_accepts: got %0d want %0d", accepts, OSTD); miscompares++; end
    rl0 = rlast_cnt;
    r_hold = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (addr_ok_o === 1'b1) begin
        got = 1;
        vectors++;
        if (rlast_cnt <= rl0) begin
          $display("FAIL ostd_third_early: got %0d rlasts want >%0d", rlast_cnt, rl0); miscompares++;
        end
      end
      tick();
    end
    req = 0;
    vectors++;
    if (!got) begin $display("FAIL ostd_third: got no addr_ok want addr_ok"); miscompares++; end
    drain();
  endtask

  task automatic test_flush();
    int d0 = dok_cnt;
    r_hold = 1;
    issue(32'h1C00_0200);
    issue(32'h1C00_0300);
    flush = 1;
    tick();
    flush = 0; r_hold = 0;
    issue(32'h1C00_0100);
    drain();
    vectors += 3;
    if (dok_cnt - d0 != 1) begin $display("FAIL flush_dok_count: got %0d want 1", dok_cnt - d0); miscompares++; end
    if (rdata_o !== {mem(32'h1C00_0104), mem(32'h1C00_0100)}) begin
      $display("FAIL flush_data: got %h want %h", rdata_o, {mem(32'h1C00_0104), mem(32'h1C00_0100)}); miscompares++;
    end
    if (u_dut.u_trk.cancel_q !== 3'd0) begin
      $display("FAIL flush_cancel: got %0d want 0", u_dut.u_trk.cancel_q); miscompares++;
    end
  endtask

  task automatic test_flush_ar_send();
    int d0, a0;
    ar_mode = 1;
    tick(); tick();
    d0 = dok_cnt; a0 = ar_cnt;
    issue(32'h1C00_0400);
    flush = 1;
    @(negedge clk);
    vectors++;
    if (arvalid_o !== 1'b1) begin $display("FAIL send_flush_arvalid: got %b want 1", arvalid_o); miscompares++; end
    tick();
    flush = 0; ar_mode = 0;
    drain();
    vectors += 3;
    if (ar_cnt - a0 != 1) begin $display("FAIL send_flush_ar: got %0d want 1", ar_cnt - a0); miscompares++; end
    if (dok_cnt != d0) begin $display("FAIL send_flush_dok: got %0d want 0", dok_cnt - d0); miscompares++; end
    if (u_dut.u_trk.cancel_q !== 3'd0) begin
      $display("FAIL send_flush_cancel: got %0d want 0", u_dut.u_trk.cancel_q); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    int d0;
    ar_mode = 0; r_gap_pct = 0;
    issue(32'h1C00_0500);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rvalid_i && !rlast_i && rready_o) got = 1;
      else tick();
    end
    @(posedge clk);
    #1;
    rst_n = 0; req = 1; raddr = 32'h1C00_0600;
    #1;
    vectors += 3;
    if (!got) begin $display("FAIL mid_beat0: got no beat 0 want beat 0"); miscompares++; end
    if (addr_ok_o !== 1'b0 || data_ok_o !== 1'b0 || rdata_o !== 64'd0) begin
      $display("FAIL mid_rst_fetch: got %b %b %h want 0 0 0", addr_ok_o, data_ok_o, rdata_o); miscompares++;
    end
    if (arvalid_o !== 1'b0 || araddr_o !== 32'd0 || rready_o !== 1'b0 || u_dut.beat_sel_q !== 1'b0) begin
      $display("FAIL mid_rst_axi: got %b %h %b %b want 0 0 0 0",
               arvalid_o, araddr_o, rready_o, u_dut.beat_sel_q); miscompares++;
    end
    tick(); req = 0;
    tick(); rst_n = 1;
    tick(); tick();
    d0 = dok_cnt;
    issue(32'h1C00_0000);
    drain();
    vectors++;
    if (dok_cnt - d0 != 1 || rdata_o !== 64'h2222_2222_1111_1111) begin
      $display("FAIL mid_refetch: got %0d %h want 1 2222222211111111", dok_cnt - d0, rdata_o); miscompares++;
    end
  endtask

  task automatic test_random();
    int d0 = dok_cnt;
    int e0 = exp_dok_total;
    ar_mode = 2; r_gap_pct = 30; r_hold = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      req   = ($urandom_range(0, 99) < 55);
      raddr = $urandom() & 32'hFFFF_FFFC;
      flush = ($urandom_range(0, 99) < 4);
    end
    drain();
    ar_mode = 0; r_gap_pct = 0;
    vectors++;
    if (dok_cnt - d0 != exp_dok_total - e0) begin
      $display("FAIL random_dok_count: got %0d want %0d", dok_cnt - d0, exp_dok_total - e0); miscompares++;
    end
  endtask

  initial begin
    rst_n = 0; req = 0; raddr = '0; flush = 0;
    arready_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
    test_reset();
    test_single();
    test_ar_stall();
    test_ostd_limit();
    test_flush();
    test_flush_ar_send();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish by 300000");
    $fatal(1);
  end

endmodule
